// File: rtl/rx_pkt_writer.sv
// rx_pkt_writer: lands packets from switch egress port 0 into per-id receive slots in the rx buffer.
// Latency: one cycle per accepted word; IDLE and DONE each add one cycle per packet.
// Backpressure: flit_ready follows mem write acceptance (mem_stall) and slot_busy; dropped flits never stall.
// Optional build macro RX_PKT_WRITER_STATS_EN adds saturating stat_flits / stat_drops counters.

package rx_pkt_writer_pkg;
  localparam int PKT_ID_WIDTH     = 2;
  localparam int PKT_LENGTH_WIDTH = 8;

  typedef logic [PKT_ID_WIDTH-1:0] pkt_id_t;

  typedef struct packed {
    logic [1:0]  vc;
    pkt_id_t     id;
    logic        req;
    logic [31:0] payload;
  } flit_t;

  // Packet length in flits (header included) lives in the low byte of the header payload.
  function automatic logic [PKT_LENGTH_WIDTH-1:0] expected_num_flits(input logic [31:0] payload);
    return payload[PKT_LENGTH_WIDTH-1:0];
  endfunction
endpackage

module rx_pkt_writer
  import rx_pkt_writer_pkg::*;
#(
  parameter int          NUM_MSGS      = 4,
  parameter logic [31:0] RX_BASE_ADDR  = 32'h2000,
  parameter int          MAX_PKT_WORDS = 32
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        flit_valid,
  input  flit_t                       flit_in,
  output logic                        flit_ready,
  output logic                        credit_return,
  output logic                        mem_wen,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_stall,
  input  logic [NUM_MSGS-1:0]         slot_busy,
  output logic                        pkt_done,
  output pkt_id_t                     pkt_done_id,
  output logic [PKT_LENGTH_WIDTH-1:0] pkt_done_len,
  output logic                        pkt_err
`ifdef RX_PKT_WRITER_STATS_EN
  ,
  output logic [31:0]                 stat_flits,
  output logic [31:0]                 stat_drops
`endif
);

  typedef logic [PKT_LENGTH_WIDTH-1:0] len_t;
  typedef enum logic [2:0] {IDLE, HDR, BODY, DROP, DONE} state_t;

  localparam logic [31:0] SLOT_STRIDE = 32'(MAX_PKT_WORDS * 4);
  localparam logic [31:0] MAX_WORDS   = 32'(MAX_PKT_WORDS);

  state_t      state_q, state_d;
  pkt_id_t     id_q, id_d;
  len_t        len_q, len_d;
  len_t        cnt_q, cnt_d;   // word index within the slot, header = 0
  len_t        rem_q, rem_d;   // flits still to be swallowed while dropping
  logic        credit_q;

  len_t        hdr_len;
  logic        hdr_bad;
  logic        id_match;
  logic        in_busy;
  logic        id_valid;
  logic [31:0] slot_base;
  logic        unused_fields;

  // vc and req carry no meaning for a single-port receiver.
  assign unused_fields = ^{flit_in.vc, flit_in.req};

  assign hdr_len   = expected_num_flits(flit_in.payload);
  assign id_match  = (flit_in.id == id_q);
  assign slot_base = RX_BASE_ADDR + 32'(id_q) * SLOT_STRIDE;
  // An id with no slot behind it is treated like a malformed header and dropped.
  assign hdr_bad   = (hdr_len == '0) || (32'(hdr_len) > MAX_WORDS) || !id_valid;

  // Slot ownership of the incoming id, and whether the latched id names a real slot.
  always_comb begin
    in_busy  = 1'b0;
    id_valid = 1'b0;
    for (int i = 0; i < NUM_MSGS; i++) begin
      if (32'(flit_in.id) == i) in_busy = slot_busy[i];
      if (32'(id_q) == i)       id_valid = 1'b1;
    end
  end

  // Next-state and output decode; flit_ready is the write accept itself for data words.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    rem_d        = rem_q;
    flit_ready   = 1'b0;
    mem_wen      = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    pkt_done     = 1'b0;
    pkt_done_id  = '0;
    pkt_done_len = '0;
    pkt_err      = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (flit_valid) begin
          id_d = flit_in.id;
          if (!in_busy) state_d = HDR;
        end
      end

      HDR: begin
        if (flit_valid) begin
          len_d = hdr_len;
          if (hdr_bad) begin
            // Swallow the header without touching memory; the rest of the packet follows in DROP.
            flit_ready = 1'b1;
            pkt_err    = 1'b1;
            if (hdr_len <= len_t'(1)) begin
              state_d = IDLE;
            end else begin
              rem_d   = hdr_len - len_t'(1);
              state_d = DROP;
            end
          end else begin
            mem_wen    = 1'b1;
            mem_addr   = slot_base;
            mem_wdata  = flit_in.payload;
            flit_ready = !mem_stall;
            if (!mem_stall) begin
              cnt_d   = len_t'(1);
              state_d = (hdr_len == len_t'(1)) ? DONE : BODY;
            end
          end
        end
      end

      BODY: begin
        if (flit_valid) begin
          if (!id_match) begin
            // A foreign flit counts as one of this packet's remaining flits.
            flit_ready = 1'b1;
            pkt_err    = 1'b1;
            rem_d      = len_q - cnt_q - len_t'(1);
            state_d    = DROP;
          end else begin
            mem_wen    = 1'b1;
            mem_addr   = slot_base + (32'(cnt_q) << 2);
            mem_wdata  = flit_in.payload;
            flit_ready = !mem_stall;
            if (!mem_stall) begin
              cnt_d = cnt_q + len_t'(1);
              if (cnt_q == len_q - len_t'(1)) state_d = DONE;
            end
          end
        end
      end

      DROP: begin
        if (rem_q == '0) begin
          state_d = IDLE;
        end else if (flit_valid) begin
          flit_ready = 1'b1;
          pkt_err    = !id_match;
          rem_d      = rem_q - len_t'(1);
          if (rem_q == len_t'(1)) state_d = IDLE;
        end
      end

      DONE: begin
        pkt_done     = 1'b1;
        pkt_done_id  = id_q;
        pkt_done_len = len_q;
        cnt_d        = '0;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and packet context registers; reset abandons any packet in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
    end
  end

  // One credit back to the switch the cycle after every consumed flit, dropped ones included.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) credit_q <= 1'b0;
    else        credit_q <= flit_ready;
  end

  assign credit_return = credit_q;

`ifdef RX_PKT_WRITER_STATS_EN
  logic [31:0] flits_q;
  logic [31:0] drops_q;

  // Saturating counters of consumed flits and pkt_err pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      flits_q <= '0;
      drops_q <= '0;
    end else begin
      if (flit_ready && (flits_q != 32'hFFFF_FFFF)) flits_q <= flits_q + 32'd1;
      if (pkt_err && (drops_q != 32'hFFFF_FFFF))    drops_q <= drops_q + 32'd1;
    end
  end

  assign stat_flits = flits_q;
  assign stat_drops = drops_q;
`endif

endmodule

// File: tb/tb_rx_pkt_writer.sv
// tb_rx_pkt_writer: directed scenarios plus randomized packet traffic against a packet-level model.
// Model predicts per-packet write lists, completions, error pulses and credit totals.
// Stall and slot_busy are randomized in the random phase; directed cases force them.
module tb_rx_pkt_writer;
  import rx_pkt_writer_pkg::*;

  localparam int          NMSG = 4;
  localparam logic [31:0] BASE = 32'h2000;
  localparam int          MAXW = 32;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        flit_valid;
  flit_t       flit_in;
  logic        flit_ready;
  logic        credit_return;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_stall;
  logic [NMSG-1:0] slot_busy;
  logic        pkt_done;
  pkt_id_t     pkt_done_id;
  logic [PKT_LENGTH_WIDTH-1:0] pkt_done_len;
  logic        pkt_err;
`ifdef RX_PKT_WRITER_STATS_EN
  logic [31:0] stat_flits;
  logic [31:0] stat_drops;
`endif

  logic stall_rand_en, stall_rand, stall_force;
  logic busy_rand_en;
  logic [NMSG-1:0] busy_rand, busy_force;
  assign mem_stall = stall_rand_en ? stall_rand : stall_force;
  assign slot_busy = busy_rand_en ? busy_rand : busy_force;

  rx_pkt_writer #(.NUM_MSGS(NMSG), .RX_BASE_ADDR(BASE), .MAX_PKT_WORDS(MAXW)) dut (
    .clk(clk), .n_rst(n_rst), .flit_valid(flit_valid), .flit_in(flit_in),
    .flit_ready(flit_ready), .credit_return(credit_return), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_stall(mem_stall),
    .slot_busy(slot_busy), .pkt_done(pkt_done), .pkt_done_id(pkt_done_id),
    .pkt_done_len(pkt_done_len), .pkt_err(pkt_err)
`ifdef RX_PKT_WRITER_STATS_EN
    , .stat_flits(stat_flits), .stat_drops(stat_drops)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Packet-level model state.
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  pkt_id_t     exp_did[$];
  logic [7:0]  exp_dlen[$];
  int          err_pending = 0;
  int          exp_credits = 0;
  int          exp_errs = 0;
  int          stat_base_credits = 0;
  int          stat_base_errs = 0;
  logic [31:0] cur_pay[$];
  pkt_id_t     cur_id[$];

  // Observation counters kept by the monitor.
  int          cnt_credit = 0, cnt_err = 0, cnt_wen = 0, cnt_done = 0;
  logic [31:0] obs_wa[$];
  logic [31:0] last_wr_addr = 32'd0;
  pkt_id_t     last_done_id = '0;
  logic [7:0]  last_done_len = 8'd0;
  logic        prev_consume = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic fail_msg(input string name, input string act, input string req);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=%s required=%s", name, act, req);
  endtask

  function automatic logic [31:0] slot_addr(input pkt_id_t id, input int n);
    return BASE + 32'(id) * 32'(MAXW * 4) + 32'(n * 4);
  endfunction

  // Per-cycle compare of DUT outputs against the model queues.
  always @(negedge clk) begin
    if (!n_rst) begin
      check("rst_ctl", {27'd0, flit_ready, credit_return, mem_wen, pkt_done, pkt_err}, 32'd0);
      check("rst_addr", mem_addr, 32'd0);
      check("rst_wdata", mem_wdata, 32'd0);
      check("rst_done_fields", {22'd0, pkt_done_id, pkt_done_len}, 32'd0);
      prev_consume = 1'b0;
    end else begin
      check("credit_return", {31'd0, credit_return}, {31'd0, prev_consume});
      if (flit_ready && !flit_valid) fail_msg("ready_without_valid", "flit_ready=1", "flit_ready=0");
      if (mem_wen) begin
        cnt_wen++;
        check("ready_eq_accept", {31'd0, flit_ready}, {31'd0, !mem_stall});
        if (exp_wa.size() == 0) begin
          fail_msg("wr_unexpected", $sformatf("write %h", mem_addr), "no write");
        end else if (mem_stall) begin
          check("stall_hold_addr", mem_addr, exp_wa[0]);
          check("stall_hold_data", mem_wdata, exp_wd[0]);
        end else begin
          check("wr_addr", mem_addr, exp_wa[0]);
          check("wr_data", mem_wdata, exp_wd[0]);
          obs_wa.push_back(mem_addr);
          last_wr_addr = mem_addr;
          void'(exp_wa.pop_front());
          void'(exp_wd.pop_front());
        end
      end
      if (pkt_done) begin
        cnt_done++;
        last_done_id  = pkt_done_id;
        last_done_len = pkt_done_len;
        if (exp_did.size() == 0) begin
          fail_msg("done_unexpected", $sformatf("done id %0d", pkt_done_id), "no done");
        end else begin
          check("done_id", 32'(pkt_done_id), 32'(exp_did[0]));
          check("done_len", 32'(pkt_done_len), 32'(exp_dlen[0]));
          void'(exp_did.pop_front());
          void'(exp_dlen.pop_front());
        end
      end
      if (pkt_err) begin
        cnt_err++;
        if (err_pending == 0) fail_msg("err_unexpected", "pkt_err=1", "no pkt_err");
        else err_pending--;
      end
      if (credit_return) cnt_credit++;
      prev_consume = flit_valid && flit_ready;
    end
  end

  // Background random stall and slot ownership, changed just after each rising edge.
  initial begin
    stall_rand = 1'b0;
    busy_rand  = '0;
    forever begin
      @(posedge clk);
      #1;
      stall_rand = ($urandom_range(0, 3) == 0);
      busy_rand  = NMSG'($urandom) & NMSG'($urandom) & NMSG'($urandom);
    end
  end

  // Build one packet's flits and push what the receiver must do with them.
  task automatic build_pkt(input pkt_id_t id, input int len, input int corrupt_at);
    int nflits, nw;
    logic [31:0] r;
    pkt_id_t other;
    r = $urandom;
    other = id + pkt_id_t'($urandom_range(1, 3));
    nflits = (len == 0) ? 1 : len;
    cur_pay.delete();
    cur_id.delete();
    for (int i = 0; i < nflits; i++) begin
      cur_pay.push_back((i == 0) ? {r[31:8], 8'(len)} : $urandom);
      cur_id.push_back((corrupt_at > 0 && i == corrupt_at) ? other : id);
    end
    exp_credits += nflits;
    if (len == 0 || len > MAXW) begin
      err_pending++;
      exp_errs++;
    end else begin
      nw = (corrupt_at > 0) ? corrupt_at : len;
      for (int i = 0; i < nw; i++) begin
        exp_wa.push_back(slot_addr(id, i));
        exp_wd.push_back(cur_pay[i]);
      end
      if (corrupt_at > 0) begin
        err_pending++;
        exp_errs++;
      end else begin
        exp_did.push_back(id);
        exp_dlen.push_back(8'(len));
      end
    end
  endtask

  task automatic send_flit(input pkt_id_t id, input logic [31:0] pay);
    int t;
    flit_in.vc      = 2'($urandom);
    flit_in.id      = id;
    flit_in.req     = 1'b1;
    flit_in.payload = pay;
    flit_valid      = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!flit_ready && t < 400);
    if (!flit_ready) fail_msg("flit_timeout", "no flit_ready", "flit_ready within 400 cycles");
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
  endtask

  task automatic send_cur(input bit gaps);
    for (int i = 0; i < cur_pay.size(); i++) begin
      send_flit(cur_id[i], cur_pay[i]);
      if (gaps) repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=simulation still running required=finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, e0, w0, d0, len, cor;
    n_rst = 1'b0;
    flit_valid = 1'b0;
    flit_in = '0;
    stall_rand_en = 1'b0;
    stall_force = 1'b0;
    busy_rand_en = 1'b0;
    busy_force = '0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // id 2, four flits, no stall.
    obs_wa.delete();
    c0 = cnt_credit; d0 = cnt_done;
    build_pkt(2'd2, 4, 0);
    send_cur(0);
    settle();
    check("basic_nwrites", 32'(obs_wa.size()), 32'd4);
    if (obs_wa.size() == 4) begin
      check("basic_addr0", obs_wa[0], 32'h2100);
      check("basic_addr1", obs_wa[1], 32'h2104);
      check("basic_addr2", obs_wa[2], 32'h2108);
      check("basic_addr3", obs_wa[3], 32'h210C);
    end
    check("basic_credits", 32'(cnt_credit - c0), 32'd4);
    check("basic_done_cnt", 32'(cnt_done - d0), 32'd1);
    check("basic_done_id", 32'(last_done_id), 32'd2);
    check("basic_done_len", 32'(last_done_len), 32'd4);

    // Same packet with word 1 stalled for three cycles.
    build_pkt(2'd2, 4, 0);
    send_flit(cur_id[0], cur_pay[0]);
    flit_in.id = cur_id[1];
    flit_in.payload = cur_pay[1];
    flit_valid = 1'b1;
    stall_force = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_ready_low", {31'd0, flit_ready}, 32'd0);
      check("stall_addr_held", mem_addr, 32'h2104);
    end
    @(posedge clk);
    #1;
    stall_force = 1'b0;
    for (int i = 1; i < 4; i++) send_flit(cur_id[i], cur_pay[i]);
    settle();
    check("stall_done_len", 32'(last_done_len), 32'd4);

    // Oversize header: 40 flits swallowed, one error, then a normal packet.
    c0 = cnt_credit; e0 = cnt_err; w0 = cnt_wen;
    build_pkt(2'd3, 40, 0);
    send_cur(0);
    settle();
    check("oversize_credits", 32'(cnt_credit - c0), 32'd40);
    check("oversize_err", 32'(cnt_err - e0), 32'd1);
    check("oversize_no_wen", 32'(cnt_wen - w0), 32'd0);
    d0 = cnt_done;
    build_pkt(2'd0, 3, 0);
    send_cur(0);
    settle();
    check("after_drop_done", 32'(cnt_done - d0), 32'd1);
    check("after_drop_len", 32'(last_done_len), 32'd3);

    // Slot 1 owned by software while its header waits.
    busy_force = 4'b0010;
    build_pkt(2'd1, 1, 0);
    flit_in.id = 2'd1;
    flit_in.payload = cur_pay[0];
    flit_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("busy_ready_low", {31'd0, flit_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    busy_force = '0;
    send_flit(2'd1, cur_pay[0]);
    settle();
    check("busy_release_addr", last_wr_addr, 32'h2080);
    check("busy_release_done_id", 32'(last_done_id), 32'd1);

    // Reset after two of four flits, with word 2 pending under stall.
    d0 = cnt_done;
    cur_pay.delete();
    cur_pay.push_back({24'h5A5A5A, 8'd4});
    cur_pay.push_back($urandom);
    cur_pay.push_back($urandom);
    for (int i = 0; i < 3; i++) begin
      exp_wa.push_back(slot_addr(2'd2, i));
      exp_wd.push_back(cur_pay[i]);
    end
    exp_credits += 2;
    send_flit(2'd2, cur_pay[0]);
    send_flit(2'd2, cur_pay[1]);
    flit_in.payload = cur_pay[2];
    flit_valid = 1'b1;
    stall_force = 1'b1;
    @(negedge clk);
    check("pre_reset_wen", {31'd0, mem_wen}, 32'd1);
    #2;
    n_rst = 1'b0;
    #1;
    check("reset_now_wen", {31'd0, mem_wen}, 32'd0);
    check("reset_now_addr", mem_addr, 32'd0);
    check("reset_now_wdata", mem_wdata, 32'd0);
    check("reset_now_ready", {31'd0, flit_ready}, 32'd0);
    void'(exp_wa.pop_back());
    void'(exp_wd.pop_back());
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
    stall_force = 1'b0;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    stat_base_credits = exp_credits;
    stat_base_errs = exp_errs;
    check("reset_no_done", 32'(cnt_done - d0), 32'd0);
    build_pkt(2'd2, 2, 0);
    send_cur(0);
    settle();
    check("post_reset_done", 32'(cnt_done - d0), 32'd1);
    check("post_reset_len", 32'(last_done_len), 32'd2);

    // Randomized traffic.
    stall_rand_en = 1'b1;
    busy_rand_en = 1'b1;
    for (int p = 0; p < 60; p++) begin
      case ($urandom_range(0, 19))
        0:       len = 0;
        1:       len = 33 + int'($urandom_range(0, 12));
        2:       len = 32;
        default: len = 1 + int'($urandom_range(0, 5));
      endcase
      cor = 0;
      if (len >= 2 && len <= MAXW && $urandom_range(0, 6) == 0) cor = int'($urandom_range(1, len - 1));
      build_pkt(pkt_id_t'($urandom_range(0, 3)), len, cor);
      send_cur(1);
    end
    stall_rand_en = 1'b0;
    busy_rand_en = 1'b0;
    settle();

    check("end_writes_left", 32'(exp_wa.size()), 32'd0);
    check("end_dones_left", 32'(exp_did.size()), 32'd0);
    check("end_errs_left", 32'(err_pending), 32'd0);
    check("end_credit_total", 32'(cnt_credit), 32'(exp_credits));
`ifdef RX_PKT_WRITER_STATS_EN
    check("stat_flits", stat_flits, 32'(exp_credits - stat_base_credits));
    check("stat_drops", stat_drops, 32'(exp_errs - stat_base_errs));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rx_pkt_writer.md
RX_PKT_WRITER -- requirements
Module: rx_pkt_writer

Interface
REQ-001 SHALL have parameter NUM_MSGS, default 4: number of receive slots, one per packet id.
REQ-002 SHALL have parameter RX_BASE_ADDR, default 32'h2000: byte address of slot 0.
REQ-003 SHALL have parameter MAX_PKT_WORDS, default 32: words per slot; slot stride = MAX_PKT_WORDS*4 bytes.
REQ-004 SHALL have port clk, input, 1: single clock; port n_rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port flit_valid, input, 1: switch egress port 0 holds a flit.
REQ-006 SHALL have port flit_in, input, flit_t: flit with vc, id, req, payload[31:0].
REQ-007 SHALL have port flit_ready, output, 1: flit consumed this cycle.
REQ-008 SHALL have port credit_return, output, 1: one-cycle pulse per consumed flit, returned to switch.
REQ-009 SHALL have ports mem_wen output 1, mem_addr output 32, mem_wdata output 32, mem_stall input 1: rx buffer write port.
REQ-010 SHALL have port slot_busy, input, NUM_MSGS: slot still owned by software.
REQ-011 SHALL have ports pkt_done output 1, pkt_done_id output pkt_id_t, pkt_done_len output PKT_LENGTH_WIDTH: completion pulse.
REQ-012 SHALL have port pkt_err, output, 1: one-cycle pulse on dropped packet.

Function
REQ-013 SHALL implement states IDLE, HDR, BODY, DROP, DONE.
REQ-014 IDLE: on flit_valid, latch id; if slot_busy[id]=0 go HDR, else hold IDLE with flit_ready=0.
REQ-015 HDR: expected length = expected_num_flits(payload), latched; if length > MAX_PKT_WORDS or 0, consume header without writing, pulse pkt_err, go DROP (or IDLE if length<=1).
REQ-016 HDR otherwise: mem_wen=1, addr = RX_BASE_ADDR + id*MAX_PKT_WORDS*4 + 0, wdata = payload; on accept go BODY, or DONE if length=1.
REQ-017 Write accepted iff mem_wen=1 and mem_stall=0; flit_ready SHALL equal accept, combinationally, same cycle.
REQ-018 BODY: word counter n (header = 0); addr = slot base + n*4; counter increments only on accept; after word length-1 accepted go DONE.
REQ-019 BODY/DROP: flit with id different from latched id SHALL be consumed, not written, pulse pkt_err, go DROP.
REQ-020 DROP: consume (flit_ready=flit_valid) until remaining count reaches 0, no writes, then IDLE.
REQ-021 DONE: one-cycle pkt_done with latched id and length, then IDLE; flit_ready=0 in DONE.
REQ-022 credit_return SHALL pulse the cycle after each consumed flit, including dropped ones; back-to-back consumes give back-to-back pulses.
REQ-023 mem_addr/mem_wdata SHALL hold stable while mem_stall=1.
REQ-024 Address arithmetic 32-bit, wraps modulo 2^32.

Reset
REQ-025 On n_rst=0, asynchronously: state IDLE, counters 0, latched id/length 0.
REQ-026 During reset all outputs 0: flit_ready, credit_return, mem_wen, pkt_done, pkt_err, mem_addr, mem_wdata, pkt_done_id, pkt_done_len.
REQ-027 Reset mid-packet SHALL abandon the packet with no pkt_done; first flit after reset is treated as a header.

Configuration
REQ-028 Macro RX_PKT_WRITER_STATS_EN SHALL, when defined, add 32-bit outputs stat_flits (consumed flits) and stat_drops (pkt_err pulses), reset 0, saturating at 32'hFFFF_FFFF.
REQ-029 Without RX_PKT_WRITER_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-030 id=2, 4-flit packet, no stall -> writes at 0x2100,0x2104,0x2108,0x210C; 4 credit pulses; pkt_done id=2 len=4.
REQ-031 Same packet, mem_stall=1 for 3 cycles on word 1 -> flit_ready low 3 cycles, addr 0x2104 held, data order intact.
REQ-032 Header length 40 (>32) -> no mem_wen, pkt_err once, 40 credits, next packet received normally.
REQ-033 slot_busy[1]=1 with id=1 header pending 5 cycles -> flit_ready=0 throughout; release -> header written to 0x2080.
REQ-034 n_rst asserted after 2 of 4 flits -> outputs 0 immediately; no pkt_done; next flit parsed as header.
REQ-035 With RX_PKT_WRITER_STATS_EN, one good 4-flit and one dropped 3-flit packet -> stat_flits=7, stat_drops=1.
